// File: rtl/dbc_port_pkg.sv
// Shared types and constants for the DbC port status-change event controller.
package dbc_port_pkg;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        IDLE     = 2'd1,
        REQ      = 2'd2,
        HOLD     = 2'd3
    } port_evt_state_t;

    localparam int CHG_CSC = 0;
    localparam int CHG_PRC = 1;
    localparam int CHG_PLC = 2;
    localparam int CHG_CEC = 3;
    localparam int CHG_W   = 4;

    typedef logic [CHG_W-1:0] chg_t;

    // Gather the four change pulses into one vector in status-bit order.
    function automatic chg_t pack_sets(input logic csc, input logic prc,
                                       input logic plc, input logic cec);
        chg_t v;
        v          = '0;
        v[CHG_CSC] = csc;
        v[CHG_PRC] = prc;
        v[CHG_PLC] = plc;
        v[CHG_CEC] = cec;
        return v;
    endfunction

endpackage

// File: rtl/dbc_port_event_ctrl_if.sv
// Event request handshake between the port event controller and the event ring arbiter.
interface dbc_port_event_ctrl_if;
    import dbc_port_pkg::*;

    // Handshake: evt_req rises with evt_mask valid and both stay frozen until an
    // edge samples evt_gnt=1; that edge completes the transfer. evt_gnt is ignored
    // whenever evt_req is low.
    logic evt_req;
    logic evt_gnt;
    chg_t evt_mask;

    modport master (output evt_req, output evt_mask, input evt_gnt);
    modport slave  (input evt_req, input evt_mask, output evt_gnt);

endinterface

// File: rtl/dbc_chg_sticky.sv
// Sticky port change bits with write-1-to-clear and the per-bit "already reported" record.
module dbc_chg_sticky
    import dbc_port_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  chg_t set_bits,
    input  logic w1c_valid,
    input  chg_t w1c_mask,
    input  logic rpt_load,
    input  chg_t rpt_mask,
    output chg_t sts_chg,
    output chg_t reported
);

    chg_t clr_bits;
    chg_t sts_next;
    chg_t rpt_next;

    // A set pulse beats a same-cycle clear; a reported bit never outlives its status bit,
    // so a stale grant cannot hide a later set of the same bit.
    always_comb begin
        clr_bits = w1c_valid ? w1c_mask : '0;
        sts_next = set_bits | (sts_chg & ~clr_bits);
        rpt_next = (reported | (rpt_load ? rpt_mask : '0)) & ~clr_bits & sts_next;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sts_chg  <= '0;
            reported <= '0;
        end else if (!enable) begin
            sts_chg  <= '0;
            reported <= '0;
        end else begin
            sts_chg  <= sts_next;
            reported <= rpt_next;
        end
    end

endmodule

// File: rtl/dbc_port_event_ctrl.sv
// Port Status Change event sequencer: sticky change bits, one event per new group, holdoff.
module dbc_port_event_ctrl
    import dbc_port_pkg::*;
#(
    parameter int HOLDOFF = 8,
    parameter int CNT_W   = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   dce,
    input  logic                   csc_set,
    input  logic                   prc_set,
    input  logic                   plc_set,
    input  logic                   cec_set,
    input  logic                   w1c_valid,
    input  chg_t                   w1c_mask,
    dbc_port_event_ctrl_if.master  evt,
    output chg_t                   sts_chg,
    output logic [CNT_W-1:0]       evt_cnt,
    output port_evt_state_t        state_dbg
);

    localparam logic [7:0] HOLD_LOAD = 8'(HOLDOFF - 1);

    port_evt_state_t  state_q, state_d;
    chg_t             mask_q, mask_d;
    logic [7:0]       hold_q, hold_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rpt_load;
    logic             sticky_en;
    chg_t             reported;
    chg_t             new_bits;

    assign sticky_en = dce && (state_q != DISABLED);
    assign new_bits  = sts_chg & ~reported;

    dbc_chg_sticky u_sticky (
        .clock     (clock),
        .reset     (reset),
        .enable    (sticky_en),
        .set_bits  (pack_sets(csc_set, prc_set, plc_set, cec_set)),
        .w1c_valid (w1c_valid),
        .w1c_mask  (w1c_mask),
        .rpt_load  (rpt_load),
        .rpt_mask  (mask_q),
        .sts_chg   (sts_chg),
        .reported  (reported)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= DISABLED;
            mask_q  <= '0;
            hold_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        hold_d   = hold_q;
        cnt_d    = cnt_q;
        rpt_load = 1'b0;
        if (!dce) begin
            state_d = DISABLED;
            mask_d  = '0;
            hold_d  = '0;
        end else begin
            case (state_q)
                DISABLED: state_d = IDLE;
                IDLE: begin
                    if (new_bits != '0) begin
                        state_d = REQ;
                        mask_d  = new_bits;
                    end
                end
                REQ: begin
                    // The mask stays frozen here even if software clears its bits;
                    // the event still goes out.
                    if (evt.evt_gnt) begin
                        rpt_load = 1'b1;
                        cnt_d    = cnt_q + CNT_W'(1);
                        hold_d   = HOLD_LOAD;
                        mask_d   = '0;
                        state_d  = HOLD;
                    end
                end
                HOLD: begin
                    if (hold_q == 8'd0) state_d = IDLE;
                    else                hold_d  = hold_q - 8'd1;
                end
                default: state_d = DISABLED;
            endcase
        end
    end

    assign evt.evt_req  = (state_q == REQ);
    assign evt.evt_mask = mask_q;
    assign evt_cnt      = cnt_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_dbc_port_event_ctrl.sv
// Directed bench for dbc_port_event_ctrl with hand-computed expectations (HOLDOFF=8, CNT_W=8).
module tb_dbc_port_event_ctrl;
    import dbc_port_pkg::*;

    logic            clock;
    logic            reset;
    logic            dce;
    logic            csc_set;
    logic            prc_set;
    logic            plc_set;
    logic            cec_set;
    logic            w1c_valid;
    chg_t            w1c_mask;
    chg_t            sts_chg;
    logic [7:0]      evt_cnt;
    port_evt_state_t state_dbg;

    int errors = 0;
    int checks = 0;
    int exp_cnt;

    dbc_port_event_ctrl_if evt_if ();

    dbc_port_event_ctrl #(.HOLDOFF(8), .CNT_W(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .dce       (dce),
        .csc_set   (csc_set),
        .prc_set   (prc_set),
        .plc_set   (plc_set),
        .cec_set   (cec_set),
        .w1c_valid (w1c_valid),
        .w1c_mask  (w1c_mask),
        .evt       (evt_if),
        .sts_chg   (sts_chg),
        .evt_cnt   (evt_cnt),
        .state_dbg (state_dbg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One active edge, then sample 1 time unit later and drop all one-cycle pulses.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            csc_set        = 1'b0;
            prc_set        = 1'b0;
            plc_set        = 1'b0;
            cec_set        = 1'b0;
            w1c_valid      = 1'b0;
            w1c_mask       = '0;
            evt_if.evt_gnt = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1; dce = 1'b0;
        csc_set = 1'b0; prc_set = 1'b0; plc_set = 1'b0; cec_set = 1'b0;
        w1c_valid = 1'b0; w1c_mask = '0; evt_if.evt_gnt = 1'b0;
        tick(2);
        check("rst_req",   32'(evt_if.evt_req),  32'd0);
        check("rst_mask",  32'(evt_if.evt_mask), 32'd0);
        check("rst_sts",   32'(sts_chg),         32'd0);
        check("rst_cnt",   32'(evt_cnt),         32'd0);
        check("rst_state", 32'(state_dbg),       32'(DISABLED));
        reset = 1'b0; dce = 1'b1;
        tick();
        check("en_state", 32'(state_dbg), 32'(IDLE));

        // CSC pulse -> status, then request two cycles after the pulse
        csc_set = 1'b1; tick();
        check("csc_sts",     32'(sts_chg),        32'h1);
        check("csc_req_lat", 32'(evt_if.evt_req), 32'd0);
        tick();
        check("csc_req",  32'(evt_if.evt_req),  32'd1);
        check("csc_mask", 32'(evt_if.evt_mask), 32'h1);
        tick();
        check("csc_req_hold", 32'(evt_if.evt_req), 32'd1);
        evt_if.evt_gnt = 1'b1; tick();
        check("csc_gnt_req",   32'(evt_if.evt_req), 32'd0);
        check("csc_gnt_cnt",   32'(evt_cnt),        32'd1);
        check("csc_gnt_state", 32'(state_dbg),      32'(HOLD));
        tick(10);
        check("csc_no_rereq", 32'(evt_if.evt_req), 32'd0);
        check("csc_idle",     32'(state_dbg),      32'(IDLE));
        check("csc_sticky",   32'(sts_chg),        32'h1);

        // PRC arriving during REQ is latched but held for a later event
        w1c_valid = 1'b1; w1c_mask = 4'b0001; tick();
        check("w1c_clear", 32'(sts_chg), 32'h0);
        csc_set = 1'b1; tick(2);
        check("p3_mask", 32'(evt_if.evt_mask), 32'h1);
        prc_set = 1'b1; tick();
        check("p3_mask_frozen", 32'(evt_if.evt_mask), 32'h1);
        check("p3_sts",         32'(sts_chg),         32'h3);
        evt_if.evt_gnt = 1'b1; tick();
        check("p3_cnt", 32'(evt_cnt), 32'd2);
        tick(7);
        check("p3_hold_end",  32'(state_dbg),      32'(HOLD));
        check("p3_hold_noreq", 32'(evt_if.evt_req), 32'd0);
        tick();
        check("p3_idle", 32'(state_dbg), 32'(IDLE));
        tick();
        check("p3_req2",  32'(evt_if.evt_req),  32'd1);
        check("p3_mask2", 32'(evt_if.evt_mask), 32'h2);
        evt_if.evt_gnt = 1'b1; tick();
        check("p3_cnt2", 32'(evt_cnt), 32'd3);
        tick(8);

        // Set pulse on an already set and reported bit is absorbed
        prc_set = 1'b1; tick(3);
        check("absorb_req", 32'(evt_if.evt_req), 32'd0);
        check("absorb_sts", 32'(sts_chg),        32'h3);

        // Same-cycle set and clear: set wins, reported bit clears, new event follows
        csc_set = 1'b1; w1c_valid = 1'b1; w1c_mask = 4'b0001; tick();
        check("setclr_sts", 32'(sts_chg), 32'h3);
        tick();
        check("setclr_req",  32'(evt_if.evt_req),  32'd1);
        check("setclr_mask", 32'(evt_if.evt_mask), 32'h1);
        evt_if.evt_gnt = 1'b1; tick();
        check("setclr_cnt", 32'(evt_cnt), 32'd4);
        tick(8);

        // All four bits, then dce drops while requesting
        w1c_valid = 1'b1; w1c_mask = 4'b1111; tick();
        csc_set = 1'b1; prc_set = 1'b1; plc_set = 1'b1; cec_set = 1'b1; tick();
        check("all_sts", 32'(sts_chg), 32'hf);
        tick();
        check("all_mask", 32'(evt_if.evt_mask), 32'hf);
        dce = 1'b0; tick();
        check("dis_req",   32'(evt_if.evt_req),  32'd0);
        check("dis_mask",  32'(evt_if.evt_mask), 32'd0);
        check("dis_sts",   32'(sts_chg),         32'd0);
        check("dis_cnt",   32'(evt_cnt),         32'd4);
        check("dis_state", 32'(state_dbg),       32'(DISABLED));
        csc_set = 1'b1; plc_set = 1'b1; tick(2);
        check("dis_ignore", 32'(sts_chg), 32'd0);
        dce = 1'b1; tick();
        check("reen_state", 32'(state_dbg), 32'(IDLE));

        // Bits cleared before grant: stale event still issued, no re-request after
        csc_set = 1'b1; tick(2);
        check("stale_req", 32'(evt_if.evt_req), 32'd1);
        w1c_valid = 1'b1; w1c_mask = 4'b0001; tick();
        check("stale_sts",  32'(sts_chg),        32'd0);
        check("stale_hold", 32'(evt_if.evt_req), 32'd1);
        evt_if.evt_gnt = 1'b1; tick();
        check("stale_cnt", 32'(evt_cnt), 32'd5);
        tick(10);
        check("stale_quiet", 32'(evt_if.evt_req), 32'd0);
        csc_set = 1'b1; tick(2);
        check("stale_reset_rpt", 32'(evt_if.evt_req), 32'd1);

        // Asynchronous reset while in REQ
        #2 reset = 1'b1;
        #1;
        check("areset_req",   32'(evt_if.evt_req), 32'd0);
        check("areset_cnt",   32'(evt_cnt),        32'd0);
        check("areset_sts",   32'(sts_chg),        32'd0);
        check("areset_state", 32'(state_dbg),      32'(DISABLED));
        reset = 1'b0;
        tick();
        check("areset_idle", 32'(state_dbg), 32'(IDLE));

        // Grants while idle are ignored; 256 events wrap the counter
        evt_if.evt_gnt = 1'b1; tick();
        evt_if.evt_gnt = 1'b1; tick();
        check("idle_gnt_cnt", 32'(evt_cnt), 32'd0);
        exp_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            csc_set = 1'b1; w1c_valid = 1'b1; w1c_mask = 4'b0001; tick(2);
            if (i == 0) check("wrap_first_req", 32'(evt_if.evt_req), 32'd1);
            evt_if.evt_gnt = 1'b1; tick();
            exp_cnt++;
            evt_if.evt_gnt = 1'b1; tick();
            tick(7);
            if (i == 127) check("wrap_mid_cnt", 32'(evt_cnt), 32'(exp_cnt[7:0]));
        end
        check("wrap_cnt", 32'(evt_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
